// File: rtl/ft6_write_arbiter.sv
// Two-requester round-robin burst arbiter feeding the FT601 synchronous write bus.
// Optional per-owner transfer counters are enabled with `define FT6_ARB_STATS_EN.
module ft6_write_arbiter #(
   parameter int unsigned BURST_LEN = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        txe_n,
   output logic [31:0] d_out,
   output logic [3:0]  be,
   output logic        wr_n,
   input  logic [31:0] s0_data,
   input  logic [3:0]  s0_be,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [31:0] s1_data,
   input  logic [3:0]  s1_be,
   input  logic        s1_valid,
   output logic        s1_ready,
   output logic [1:0]  grant,
   output logic        busy
`ifdef FT6_ARB_STATS_EN
   ,
   output logic [31:0] s0_count,
   output logic [31:0] s1_count
`endif
);

   localparam int unsigned CW = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] BL = CW'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [1:0]    grant_nxt;
   logic [CW-1:0] burst_cnt, burst_cnt_nxt;
   logic          rr_s1, rr_s1_nxt;
   logic          xfer, reg_free, room, acc, sel_valid;
   logic [31:0]   sel_data;
   logic [3:0]    sel_be;

   // The output register can take a new word when it is empty or is emptying this edge.
   assign xfer     = ~wr_n & ~txe_n;
   assign reg_free = wr_n | xfer;
   assign room     = (state == BURST) & reg_free & (burst_cnt < BL) & ~rst;
   assign s0_ready = room & grant[0];
   assign s1_ready = room & grant[1];
   assign acc      = (s0_valid & s0_ready) | (s1_valid & s1_ready);
   assign busy     = (state != IDLE);

   assign sel_valid = grant[1] ? s1_valid : (grant[0] & s0_valid);
   assign sel_data  = grant[1] ? s1_data  : s0_data;
   assign sel_be    = grant[1] ? s1_be    : s0_be;

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      burst_cnt_nxt = burst_cnt;
      rr_s1_nxt     = rr_s1;
      case (state)
         IDLE: begin
            grant_nxt = 2'b00;
            if (s0_valid && (!s1_valid || !rr_s1)) begin
               grant_nxt     = 2'b01;
               rr_s1_nxt     = 1'b1;
               state_nxt     = BURST;
               burst_cnt_nxt = '0;
            end else if (s1_valid) begin
               grant_nxt     = 2'b10;
               rr_s1_nxt     = 1'b0;
               state_nxt     = BURST;
               burst_cnt_nxt = '0;
            end
         end
         BURST: begin
            if (acc) begin
               burst_cnt_nxt = burst_cnt + CW'(1);
               if (burst_cnt + CW'(1) == BL) state_nxt = DRAIN;
            end else if (!sel_valid) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Hold the grant until the last word has left, guaranteeing an idle bus cycle.
            if (reg_free) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= 2'b00;
         burst_cnt <= '0;
         rr_s1     <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         burst_cnt <= burst_cnt_nxt;
         rr_s1     <= rr_s1_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_n  <= 1'b1;
         d_out <= '0;
         be    <= '0;
      end else if (acc) begin
         wr_n  <= 1'b0;
         d_out <= sel_data;
         be    <= sel_be;
      end else if (xfer) begin
         wr_n  <= 1'b1;
      end
   end

`ifdef FT6_ARB_STATS_EN
   // The grant is held until the register drains, so it names the owner of the word on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_count <= '0;
         s1_count <= '0;
      end else if (xfer) begin
         if (grant[0]) s0_count <= s0_count + 32'd1;
         if (grant[1]) s1_count <= s1_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ft6_write_arbiter.sv
// Directed bench for ft6_write_arbiter (BURST_LEN=4): bursts, backpressure, round-robin, drop, reset.
module tb_ft6_write_arbiter;

   logic        clk = 1'b0;
   logic        rst, txe_n;
   logic [31:0] d_out, s0_data, s1_data;
   logic [3:0]  be, s0_be, s1_be;
   logic        wr_n, s0_valid, s1_valid, s0_ready, s1_ready, busy;
   logic [1:0]  grant;
`ifdef FT6_ARB_STATS_EN
   logic [31:0] s0_count, s1_count;
`endif

   typedef struct {
      logic [1:0]  g;
      logic [31:0] d;
      logic [3:0]  b;
      int          t;
   } xf_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   xf_t         log_q[$];

   always #5 clk = ~clk;

   ft6_write_arbiter #(.BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .txe_n(txe_n),
      .d_out(d_out), .be(be), .wr_n(wr_n),
      .s0_data(s0_data), .s0_be(s0_be), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_be(s1_be), .s1_valid(s1_valid), .s1_ready(s1_ready),
      .grant(grant), .busy(busy)
`ifdef FT6_ARB_STATS_EN
      , .s0_count(s0_count), .s1_count(s1_count)
`endif
   );

   // One clock: drive requesters at negedge, record bus/handshakes just before posedge,
   // return 1 unit after posedge so callers observe post-edge state.
   task automatic tick();
      @(negedge clk);
      s0_valid = (q0.size() > 0);
      s0_data  = s0_valid ? q0[0] : 32'h0;
      s0_be    = 4'hF;
      s1_valid = (q1.size() > 0);
      s1_data  = s1_valid ? q1[0] : 32'h0;
      s1_be    = 4'h3;
      #3;
      cyc++;
      if (wr_n === 1'b0 && txe_n === 1'b0) log_q.push_back('{g: grant, d: d_out, b: be, t: cyc});
      if (s0_valid && s0_ready === 1'b1) void'(q0.pop_front());
      if (s1_valid && s1_ready === 1'b1) void'(q1.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      txe_n = 1'b1;
      q0.delete();
      q1.delete();
      tick();
      tick();
      rst = 1'b0;
      log_q.delete();
   endtask

   task automatic wait_log(input int n, input int limit);
      for (int i = 0; i < limit && log_q.size() < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      txe_n = 1'b0;
      q0.push_back(32'hDEAD_BEEF);
      tick();
      tick();
      n_tests++; if (wr_n !== 1'b1)   begin n_fail++; $display("FAIL reset_wr_n got %b exp 1", wr_n); end
      n_tests++; if (d_out !== 32'h0) begin n_fail++; $display("FAIL reset_d_out got %h exp 0", d_out); end
      n_tests++; if (be !== 4'h0)     begin n_fail++; $display("FAIL reset_be got %h exp 0", be); end
      n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b exp 00", grant); end
      n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_ready got %b exp 0", s0_ready); end
`ifdef FT6_ARB_STATS_EN
      n_tests++; if (s0_count !== 32'd0 || s1_count !== 32'd0)
         begin n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", s0_count, s1_count); end
`endif
      do_reset();
   endtask

   task automatic test_single_burst();
      do_reset();
      txe_n = 1'b0;
      for (int i = 1; i <= 4; i++) q0.push_back(32'(i));
      wait_log(4, 40);
      n_tests++; if (log_q.size() != 4) begin n_fail++; $display("FAIL single_count got %0d exp 4", log_q.size()); end
      for (int i = 0; i < log_q.size() && i < 4; i++) begin
         n_tests++;
         if (log_q[i].d !== 32'(i + 1) || log_q[i].g !== 2'b01 || log_q[i].b !== 4'hF ||
             log_q[i].t != log_q[0].t + i) begin
            n_fail++;
            $display("FAIL single_word%0d got d=%h g=%b be=%h t=%0d exp d=%h g=01 be=f t=%0d",
                     i, log_q[i].d, log_q[i].g, log_q[i].b, log_q[i].t, i + 1, log_q[0].t + i);
         end
      end
      tick(); tick(); tick();
      n_tests++; if (grant !== 2'b00 || busy !== 1'b0 || wr_n !== 1'b1)
         begin n_fail++; $display("FAIL single_idle got g=%b busy=%b wr_n=%b exp 00/0/1", grant, busy, wr_n); end
   endtask

   task automatic test_backpressure();
      do_reset();
      q0.push_back(32'hA5A5_A5A5);
      q0.push_back(32'h1111_1111);
      for (int i = 0; i < 20 && wr_n !== 1'b0; i++) tick();
      n_tests++; if (wr_n !== 1'b0) begin n_fail++; $display("FAIL bp_load got wr_n=%b exp 0", wr_n); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (d_out !== 32'hA5A5_A5A5 || wr_n !== 1'b0 || s0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d got d=%h wr_n=%b rdy=%b exp a5a5a5a5/0/0", i, d_out, wr_n, s0_ready);
         end
      end
      n_tests++; if (log_q.size() != 0) begin n_fail++; $display("FAIL bp_noxfer got %0d exp 0", log_q.size()); end
      txe_n = 1'b0;
      wait_log(2, 20);
      tick(); tick(); tick();
      n_tests++;
      if (log_q.size() != 2) begin
         n_fail++; $display("FAIL bp_count got %0d exp 2", log_q.size());
      end else if (log_q[0].d !== 32'hA5A5_A5A5 || log_q[1].d !== 32'h1111_1111) begin
         n_fail++; $display("FAIL bp_data got %h,%h exp a5a5a5a5,11111111", log_q[0].d, log_q[1].d);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_d;
      int          own, idx;
      do_reset();
      txe_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         q0.push_back(32'h100 + 32'(i));
         q1.push_back(32'h200 + 32'(i));
      end
      wait_log(16, 200);
      n_tests++; if (log_q.size() != 16) begin n_fail++; $display("FAIL rr_count got %0d exp 16", log_q.size()); end
      for (int k = 0; k < log_q.size() && k < 16; k++) begin
         own   = (k / 4) % 2;
         idx   = (k / 8) * 4 + k % 4;
         exp_d = (own == 1 ? 32'h200 : 32'h100) + 32'(idx);
         n_tests++;
         if (log_q[k].d !== exp_d || log_q[k].g !== (own == 1 ? 2'b10 : 2'b01) ||
             log_q[k].b !== (own == 1 ? 4'h3 : 4'hF)) begin
            n_fail++;
            $display("FAIL rr_word%0d got d=%h g=%b be=%h exp d=%h owner s%0d", k, log_q[k].d, log_q[k].g,
                     log_q[k].b, exp_d, own);
         end
         if (k > 0 && k % 4 == 0) begin
            n_tests++;
            if (log_q[k].t - log_q[k-1].t < 2) begin
               n_fail++; $display("FAIL rr_gap%0d got %0d cycles exp >=2", k, log_q[k].t - log_q[k-1].t);
            end
         end
      end
   endtask

   task automatic test_drop();
      do_reset();
      txe_n = 1'b0;
      q1.push_back(32'hB0);
      q1.push_back(32'hB1);
      wait_log(2, 30);
      n_tests++;
      if (log_q.size() != 2 || log_q[0].d !== 32'hB0 || log_q[1].d !== 32'hB1 || log_q[1].g !== 2'b10) begin
         n_fail++; $display("FAIL drop_words got %0d words exp b0,b1 from s1", log_q.size());
      end
      for (int i = 0; i < 10 && grant !== 2'b00; i++) tick();
      n_tests++; if (grant !== 2'b00 || busy !== 1'b0)
         begin n_fail++; $display("FAIL drop_idle got g=%b busy=%b exp 00/0", grant, busy); end
      q0.push_back(32'hC0);
      wait_log(3, 30);
      n_tests++;
      if (log_q.size() != 3 || log_q[2].d !== 32'hC0 || log_q[2].g !== 2'b01) begin
         n_fail++; $display("FAIL drop_next got %0d words exp c0 from s0 third", log_q.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      q0.push_back(32'hEE);
      q0.push_back(32'hEF);
      for (int i = 0; i < 20 && wr_n !== 1'b0; i++) tick();
      n_tests++; if (wr_n !== 1'b0) begin n_fail++; $display("FAIL rstmid_load got wr_n=%b exp 0", wr_n); end
      rst = 1'b1;
      tick();
      n_tests++;
      if (wr_n !== 1'b1 || grant !== 2'b00 || busy !== 1'b0 || s0_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_state got wr_n=%b g=%b busy=%b rdy=%b exp 1/00/0/0", wr_n, grant, busy, s0_ready);
      end
      rst = 1'b0;
      q0.delete();
      txe_n = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_tests++; if (log_q.size() != 0) begin n_fail++; $display("FAIL rstmid_lost got %0d xfers exp 0", log_q.size()); end
   endtask

`ifdef FT6_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      txe_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         q0.push_back(32'h300 + 32'(i));
         q1.push_back(32'h400 + 32'(i));
      end
      wait_log(24, 300);
      n_tests++; if (s0_count !== 32'd12 || s1_count !== 32'd12)
         begin n_fail++; $display("FAIL stats_counts got %0d/%0d exp 12/12", s0_count, s1_count); end
   endtask
`endif

   initial begin
      rst = 1'b1; txe_n = 1'b1;
      s0_valid = 1'b0; s1_valid = 1'b0;
      s0_data = '0; s1_data = '0; s0_be = '0; s1_be = '0;
      test_reset();
      test_single_burst();
      test_backpressure();
      test_round_robin();
      test_drop();
      test_reset_mid();
`ifdef FT6_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ft6_write_arbiter.md
FT6_WRITE_ARBITER -- requirements
Module: ft6_write_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 256, meaning max words accepted from one requester per grant (range 1..65535).
REQ-002 Port clk  input  1  FT601 interface clock; all logic on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port txe_n  input  1  FT601 transmit-FIFO-full flag, active-low (0 = space available).
REQ-005 Port d_out  output  32  FT601 data bus, registered.
REQ-006 Port be  output  4  FT601 byte enables, registered.
REQ-007 Port wr_n  output  1  FT601 write strobe, active-low, registered.
REQ-008 Ports s0_data/s1_data  input  32  requester data words.
REQ-009 Ports s0_be/s1_be  input  4  requester byte enables.
REQ-010 Ports s0_valid/s1_valid  input  1  requester word available.
REQ-011 Ports s0_ready/s1_ready  output  1  word accepted at this edge when valid and ready both high.
REQ-012 Port grant  output  2  one-hot current owner (bit0 = s0, bit1 = s1); 2'b00 when none.
REQ-013 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Bus transfer SHALL occur on a rising edge where wr_n==0 and txe_n==0; no other edge transfers a word.
REQ-015 Output register (d_out, be) SHALL be full exactly when wr_n==0; contents held stable until transferred.
REQ-016 Word accepted at edge k SHALL appear on d_out/be with wr_n==0 after edge k (1-cycle latency).
REQ-017 txe_n==1 with register full: d_out, be, wr_n=0 held unchanged; no upstream acceptance; no data lost or duplicated.
REQ-018 sN_ready = (state==BURST) & grant[N] & (register empty | transfer this edge) & (burst_cnt < BURST_LEN); combinational on txe_n.
REQ-019 States IDLE, BURST, DRAIN; encoding free.
REQ-020 IDLE: grant=00; if any valid, grant per round-robin pointer, next state BURST, burst_cnt cleared.
REQ-021 Round-robin: both valid in IDLE -> requester not served last wins; pointer after reset favours s0; single valid requester always wins.
REQ-022 BURST: burst_cnt increments per accepted word; go to DRAIN when burst_cnt reaches BURST_LEN or granted valid low at an edge with no acceptance.
REQ-023 DRAIN: grant held, no acceptance; go to IDLE at edge where register is empty or transfers.
REQ-024 Result: at least one cycle with wr_n==1 between words of different owners.
REQ-025 burst_cnt width SHALL be clog2(BURST_LEN+1); never wraps; BURST_LEN=1 yields one word per grant.
REQ-026 Non-granted requester ready SHALL be 0 at all times.

Reset
REQ-027 rst high at an edge: state IDLE, wr_n=1, d_out=0, be=0, grant=00, busy=0, burst_cnt=0, pointer favours s0.
REQ-028 Reset mid-burst discards any held word; no transfer on the reset edge; ready low while rst high.

Configuration
REQ-029 Macro FT6_ARB_STATS_EN defined: add outputs s0_count, s1_count (32 bits, reset 0) incrementing per word of that owner transferred on bus (REQ-014), wrapping at 2^32.
REQ-030 Macro undefined: count ports and logic absent; all other behaviour identical.

Verification
REQ-031 s0 valid with 0x00000001..0x00000004, txe_n=0, s1 idle -> four consecutive wr_n=0 cycles, d_out 1,2,3,4, grant=01.
REQ-032 Register holds 0xA5A5A5A5, txe_n=1 for 5 cycles -> d_out and wr_n=0 stable, s0_ready=0; txe_n=0 -> single transfer, next word follows.
REQ-033 Both valid continuously, BURST_LEN=4 -> 4 words s0, >=1 cycle wr_n=1, 4 words s1, alternating; no word lost.
REQ-034 s1 drops valid after 2 words -> DRAIN, IDLE, grant returns 00 after last transfer; s0 served next.
REQ-035 rst asserted mid-burst with word held -> wr_n=1, grant=00 next cycle; held word never transferred.
REQ-036 With FT6_ARB_STATS_EN: run REQ-033 for 12 words each -> s0_count=12, s1_count=12.
